// File: rtl/gray2bin_arbiter_if.sv
// Bundle of requester, gray2bin and result signals for gray2bin_arbiter.
// slave is the arbiter's view; master drives the arbiter (sources, gray2bin, sink).
interface gray2bin_arbiter_if #(
  parameter int MODULATION_ORDER = 16,
  parameter int NUM_REQ          = 4
);
  localparam int W  = $clog2(MODULATION_ORDER);
  localparam int IW = $clog2(NUM_REQ);

  logic                 i_en;
  logic [NUM_REQ*W-1:0] i_req_gray;
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [W-1:0]         o_g2b_gray;
  logic                 o_g2b_dv;
  logic [W-1:0]         i_g2b_bin;
  logic                 i_g2b_dv;
  logic [W-1:0]         o_binary_code;
  logic [IW-1:0]        o_id;
  logic                 o_dv;
  logic                 o_idle;
  logic                 o_err;

  modport slave (
    input  i_en, i_req_gray, i_req_valid, i_g2b_bin, i_g2b_dv,
    output o_req_ready, o_g2b_gray, o_g2b_dv, o_binary_code, o_id, o_dv, o_idle, o_err
  );

  modport master (
    output i_en, i_req_gray, i_req_valid, i_g2b_bin, i_g2b_dv,
    input  o_req_ready, o_g2b_gray, o_g2b_dv, o_binary_code, o_id, o_dv, o_idle, o_err
  );
endinterface

// File: rtl/gray2bin_arbiter.sv
// Round-robin scheduler sharing one gray2bin between NUM_REQ symbol sources;
// results come back in order and are tagged with the originating requester.
module gray2bin_arbiter #(
  parameter int MODULATION_ORDER = 16,
  parameter int NUM_REQ          = 4,
  parameter int MAX_INFLIGHT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  gray2bin_arbiter_if.slave bus
);
  localparam int W  = $clog2(MODULATION_ORDER);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, ptr_nxt, win;
  logic               found, grant_en, accept, pop;
  logic [NUM_REQ-1:0] ready;
  logic [CW-1:0]      count;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [IW-1:0]      tags [MAX_INFLIGHT];
  logic [W-1:0]       g2b_gray, bin_q;
  logic               g2b_dv, dv_q, err_q;
  logic [IW-1:0]      id_q;

  // Grant search starts at ptr and wraps; the full check uses the registered
  // count, so a same-cycle return never frees a slot early.
  always_comb begin
    grant_en = (state == RUN) && (count < CW'(MAX_INFLIGHT));
    found    = 1'b0;
    win      = '0;
    ready    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && bus.i_req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    accept = grant_en && found;
    if (accept) ready[win] = 1'b1;
    ptr_nxt = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
    pop     = bus.i_g2b_dv && (count != '0);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.i_en) state_nxt = RUN;
      RUN:     if (!bus.i_en) state_nxt = DRAIN;
      DRAIN: begin
        if (bus.i_en)                        state_nxt = RUN;
        else if (count == '0 && !g2b_dv)     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      g2b_gray <= '0;
      g2b_dv   <= 1'b0;
      bin_q    <= '0;
      id_q     <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      g2b_dv <= accept;
      dv_q   <= pop;
      if (accept) begin
        g2b_gray <= bus.i_req_gray[32'(win)*W +: W];
        ptr      <= ptr_nxt;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) begin
        bin_q  <= bus.i_g2b_bin;
        id_q   <= tags[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (bus.i_g2b_dv && count == '0) err_q <= 1'b1;
      if (accept && !pop)      count <= count + CW'(1);
      else if (!accept && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tags[wr_ptr] <= win;
  end

  assign bus.o_req_ready   = ready;
  assign bus.o_g2b_gray    = g2b_gray;
  assign bus.o_g2b_dv      = g2b_dv;
  assign bus.o_binary_code = bin_q;
  assign bus.o_id          = id_q;
  assign bus.o_dv          = dv_q;
  assign bus.o_idle        = (state == IDLE);
  assign bus.o_err         = err_q;
endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Directed bench for gray2bin_arbiter; the bench itself plays the gray2bin role.
module tb_gray2bin_arbiter;
  localparam int MO = 16;
  localparam int NR = 4;
  localparam int MI = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gray2bin_arbiter_if #(.MODULATION_ORDER(MO), .NUM_REQ(NR)) bus ();

  gray2bin_arbiter #(.MODULATION_ORDER(MO), .NUM_REQ(NR), .MAX_INFLIGHT(MI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_en        = 1'b0;
    bus.i_req_gray  = {4'b0011, 4'b1000, 4'b0110, 4'b0001};
    bus.i_req_valid = '0;
    bus.i_g2b_bin   = '0;
    bus.i_g2b_dv    = 1'b0;

    // reset state
    #12;
    chk("rst_idle", 32'(bus.o_idle), 1);
    chk("rst_ready", 32'(bus.o_req_ready), 0);
    chk("rst_g2b_dv", 32'(bus.o_g2b_dv), 0);
    chk("rst_g2b_gray", 32'(bus.o_g2b_gray), 0);
    chk("rst_dv", 32'(bus.o_dv), 0);
    chk("rst_bin", 32'(bus.o_binary_code), 0);
    chk("rst_id", 32'(bus.o_id), 0);
    chk("rst_err", 32'(bus.o_err), 0);
    rst = 1'b1;
    bus.i_en = 1'b1;
    tick;
    chk("run_idle", 32'(bus.o_idle), 0);

    // single request from requester 1
    bus.i_req_valid = 4'b0010;
    #1 chk("t1_ready", 32'(bus.o_req_ready), 32'b0010);
    tick;
    bus.i_req_valid = '0;
    chk("t1_g2b_dv", 32'(bus.o_g2b_dv), 1);
    chk("t1_g2b_gray", 32'(bus.o_g2b_gray), 32'b0110);
    tick;
    chk("t1_g2b_dv_low", 32'(bus.o_g2b_dv), 0);
    bus.i_g2b_dv  = 1'b1;
    bus.i_g2b_bin = 4'b0100;
    tick;
    bus.i_g2b_dv = 1'b0;
    chk("t1_dv", 32'(bus.o_dv), 1);
    chk("t1_bin", 32'(bus.o_binary_code), 32'b0100);
    chk("t1_id", 32'(bus.o_id), 1);
    tick;
    chk("t1_dv_low", 32'(bus.o_dv), 0);

    // all requesters valid; pointer sits at 2 after the first accept
    bus.i_req_valid = 4'b1111;
    #1 chk("rr_ready_a", 32'(bus.o_req_ready), 32'b0100);
    tick;
    chk("rr_gray_a", 32'(bus.o_g2b_gray), 32'b1000);
    chk("rr_ready_b", 32'(bus.o_req_ready), 32'b1000);
    tick;
    chk("rr_gray_b", 32'(bus.o_g2b_gray), 32'b0011);
    chk("rr_ready_c", 32'(bus.o_req_ready), 32'b0001);
    tick;
    chk("rr_gray_c", 32'(bus.o_g2b_gray), 32'b0001);
    chk("rr_ready_d", 32'(bus.o_req_ready), 32'b0010);
    tick;
    chk("rr_gray_d", 32'(bus.o_g2b_gray), 32'b0110);
    chk("full_ready", 32'(bus.o_req_ready), 0);
    tick;
    chk("full_g2b_dv", 32'(bus.o_g2b_dv), 0);
    chk("full_ready_hold", 32'(bus.o_req_ready), 0);

    // one return while full: no bypass, then exactly one more accept
    bus.i_g2b_dv  = 1'b1;
    bus.i_g2b_bin = 4'b1111;
    #1 chk("full_nobypass", 32'(bus.o_req_ready), 0);
    tick;
    bus.i_g2b_dv = 1'b0;
    chk("ret_dv", 32'(bus.o_dv), 1);
    chk("ret_id", 32'(bus.o_id), 2);
    chk("ret_bin", 32'(bus.o_binary_code), 32'b1111);
    chk("refill_ready", 32'(bus.o_req_ready), 32'b0100);
    tick;
    chk("refill_g2b_dv", 32'(bus.o_g2b_dv), 1);
    chk("refill_gray", 32'(bus.o_g2b_gray), 32'b1000);
    chk("refull_ready", 32'(bus.o_req_ready), 0);
    chk("refull_dv", 32'(bus.o_dv), 0);

    // drain the four in flight: tags 3,0,1,2 in order
    bus.i_req_valid = '0;
    bus.i_g2b_dv    = 1'b1;
    bus.i_g2b_bin   = 4'b0010;
    tick;
    chk("seq_id0", 32'(bus.o_id), 3);
    chk("seq_bin0", 32'(bus.o_binary_code), 32'b0010);
    bus.i_g2b_bin = 4'b0001;
    tick;
    chk("seq_id1", 32'(bus.o_id), 0);
    bus.i_g2b_bin = 4'b0100;
    tick;
    chk("seq_id2", 32'(bus.o_id), 1);
    bus.i_g2b_bin = 4'b1111;
    tick;
    chk("seq_id3", 32'(bus.o_id), 2);
    chk("seq_dv3", 32'(bus.o_dv), 1);
    bus.i_g2b_dv = 1'b0;
    tick;
    chk("seq_dv_low", 32'(bus.o_dv), 0);

    // drain with three in flight (accepts 3,0,1)
    bus.i_req_valid = 4'b1111;
    #1 chk("dr_ready_a", 32'(bus.o_req_ready), 32'b1000);
    tick;
    chk("dr_ready_b", 32'(bus.o_req_ready), 32'b0001);
    tick;
    chk("dr_ready_c", 32'(bus.o_req_ready), 32'b0010);
    tick;
    bus.i_req_valid = '0;
    bus.i_en        = 1'b0;
    chk("dr_gray_c", 32'(bus.o_g2b_gray), 32'b0110);
    tick;
    bus.i_req_valid = 4'b1111;
    #1 chk("dr_ready_off", 32'(bus.o_req_ready), 0);
    chk("dr_not_idle", 32'(bus.o_idle), 0);
    bus.i_g2b_dv  = 1'b1;
    bus.i_g2b_bin = 4'b0010;
    tick;
    chk("dr_id0", 32'(bus.o_id), 3);
    chk("dr_bin0", 32'(bus.o_binary_code), 32'b0010);
    bus.i_g2b_bin = 4'b0001;
    tick;
    chk("dr_id1", 32'(bus.o_id), 0);
    bus.i_g2b_bin = 4'b0100;
    tick;
    chk("dr_id2", 32'(bus.o_id), 1);
    chk("dr_still_drain", 32'(bus.o_idle), 0);
    bus.i_g2b_dv = 1'b0;
    tick;
    chk("dr_idle", 32'(bus.o_idle), 1);
    chk("dr_idle_ready", 32'(bus.o_req_ready), 0);
    chk("dr_err_clean", 32'(bus.o_err), 0);

    // return with nothing in flight
    bus.i_g2b_dv  = 1'b1;
    bus.i_g2b_bin = 4'b1010;
    tick;
    bus.i_g2b_dv = 1'b0;
    chk("err_set", 32'(bus.o_err), 1);
    chk("err_no_dv", 32'(bus.o_dv), 0);
    tick;
    chk("err_sticky", 32'(bus.o_err), 1);
    chk("err_no_dv2", 32'(bus.o_dv), 0);

    // asynchronous reset mid-burst (pointer at 2 before reset)
    bus.i_en = 1'b1;
    tick;
    chk("mb_ready_a", 32'(bus.o_req_ready), 32'b0100);
    tick;
    chk("mb_g2b_dv", 32'(bus.o_g2b_dv), 1);
    tick;
    #2 rst = 1'b0;
    #1;
    chk("ar_ready", 32'(bus.o_req_ready), 0);
    chk("ar_g2b_dv", 32'(bus.o_g2b_dv), 0);
    chk("ar_g2b_gray", 32'(bus.o_g2b_gray), 0);
    chk("ar_idle", 32'(bus.o_idle), 1);
    chk("ar_err", 32'(bus.o_err), 0);
    tick;
    rst = 1'b1;
    tick;
    chk("ar_first_grant", 32'(bus.o_req_ready), 32'b0001);
    tick;
    bus.i_req_valid = '0;
    chk("ar_gray", 32'(bus.o_g2b_gray), 32'b0001);
    chk("ar_issue", 32'(bus.o_g2b_dv), 1);
    bus.i_g2b_dv  = 1'b1;
    bus.i_g2b_bin = 4'b0001;
    tick;
    bus.i_g2b_dv = 1'b0;
    chk("ar_ret_dv", 32'(bus.o_dv), 1);
    chk("ar_ret_id", 32'(bus.o_id), 0);
    chk("ar_ret_err", 32'(bus.o_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
